uart_mmio_port: RTL and testbench

- Memory-mapped UART responder on the CPU data bus: the peripheral end of the load/store interface the single-cycle core drives (rd_en, wr_en, addr, wdata, rdata, ready).
- Provides 8N1 serial TX/RX, status/control register, RX interrupt request.
- Stalls the core through `ready` (the core's PC-advance enable) when a TX write arrives while the transmitter is busy.

---
 rtl/uart_mmio_pkg.sv | 30 +++
 rtl/baud_tick_gen.sv | 29 ++
 rtl/uart_mmio_port.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_mmio_port.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART port: register offsets,
// CON bit positions, the common TX/RX state encoding and the address decoder.
package uart_mmio_pkg;

  localparam logic [31:0] TXD_OFF = 32'd0;
  localparam logic [31:0] RXD_OFF = 32'd4;
  localparam logic [31:0] CON_OFF = 32'd8;

  localparam int CON_TX_BUSY   = 0;
  localparam int CON_RX_VALID  = 1;
  localparam int CON_OVERRUN   = 2;
  localparam int CON_FRAME_ERR = 3;
  localparam int CON_IRQ_EN    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Word-granular address match; the byte-lane bits of the address are ignored.
  function automatic logic reg_hit(input logic [31:0] a, input logic [31:0] base,
                                   input logic [31:0] off);
    logic [31:0] target;
    target = base + off;
    return (a[31:2] == target[31:2]);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clk pulse at 16x the serial bit rate.
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mmio_port.sv
// Memory-mapped 8N1 UART on the core data bus. TXD stalls the core through
// `ready` while a frame is in flight; RXD/CON expose received data and status.
module uart_mmio_port
  import uart_mmio_pkg::*;
#(
  parameter int          CLK_HZ = 50000000,
  parameter int          BAUD   = 9600,
  parameter int          DIV    = CLK_HZ / (BAUD * 16),
  parameter logic [31:0] BASE   = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  logic w_tick;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // ---------------------------------------------------------------- decode
  logic w_hit_txd, w_hit_rxd, w_hit_con;
  logic w_wr_txd, w_rd_rxd, w_wr_con;
  logic w_unused_wdata;

  assign w_hit_txd      = reg_hit(addr, BASE, TXD_OFF);
  assign w_hit_rxd      = reg_hit(addr, BASE, RXD_OFF);
  assign w_hit_con      = reg_hit(addr, BASE, CON_OFF);
  assign w_wr_txd       = wr_en & w_hit_txd;
  assign w_rd_rxd       = rd_en & w_hit_rxd;
  assign w_wr_con       = wr_en & w_hit_con;
  assign w_unused_wdata = ^wdata[31:8];

  // ---------------------------------------------------------------- TX
  uart_state_t r_tx_state, w_tx_state_nxt;
  logic [3:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]  r_tx_idx, w_tx_idx_nxt;
  logic [7:0]  r_tx_data;
  logic        r_tx_pend;
  logic        r_uart_tx;
  logic        w_tx_line_nxt;
  logic        w_tx_busy;
  logic        w_tx_done;
  logic        w_tx_accept;

  // A byte accepted while idle waits for the next tick; it already owns the
  // transmitter, so a second store in that window must stall as well.
  assign w_tx_busy   = (r_tx_state != ST_IDLE) | r_tx_pend;
  // Last clk of the stop bit: a waiting store is accepted here and chained
  // straight into the next start bit.
  assign w_tx_done   = (r_tx_state == ST_STOP) & w_tick & (r_tx_cnt == 4'd15);
  assign ready       = ~(w_wr_txd & w_tx_busy & ~w_tx_done);
  assign w_tx_accept = w_wr_txd & ready;
  assign uart_tx     = r_uart_tx;

  // TX next-state: each non-idle state lasts 16 ticks; data bits LSB first.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    if (w_tick && (r_tx_state != ST_IDLE)) begin
      w_tx_cnt_nxt = r_tx_cnt + 4'd1;
    end
    unique case (r_tx_state)
      ST_IDLE: begin
        if (r_tx_pend && w_tick) begin
          w_tx_state_nxt = ST_START;
          w_tx_cnt_nxt   = 4'd0;
          w_tx_idx_nxt   = 3'd0;
        end
      end
      ST_START: begin
        if (w_tick && (r_tx_cnt == 4'd15)) begin
          w_tx_state_nxt = ST_DATA;
          w_tx_idx_nxt   = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_tick && (r_tx_cnt == 4'd15)) begin
          if (r_tx_idx == 3'd7) begin
            w_tx_state_nxt = ST_STOP;
          end else begin
            w_tx_idx_nxt = r_tx_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tx_done) begin
          w_tx_state_nxt = w_tx_accept ? ST_START : ST_IDLE;
          w_tx_idx_nxt   = 3'd0;
        end
      end
      default: w_tx_state_nxt = ST_IDLE;
    endcase
    unique case (w_tx_state_nxt)
      ST_START: w_tx_line_nxt = 1'b0;
      ST_DATA:  w_tx_line_nxt = r_tx_data[w_tx_idx_nxt];
      default:  w_tx_line_nxt = 1'b1;
    endcase
  end

  // TX state register; the serial line is registered so it never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= 4'd0;
      r_tx_idx   <= 3'd0;
      r_tx_pend  <= 1'b0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_uart_tx  <= w_tx_line_nxt;
      if ((r_tx_state == ST_IDLE) && (w_tx_state_nxt == ST_START)) begin
        r_tx_pend <= 1'b0;
      end else if (w_tx_accept && (w_tx_state_nxt == ST_IDLE)) begin
        r_tx_pend <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX
  uart_state_t r_rx_state, w_rx_state_nxt;
  logic [3:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_idx, w_rx_idx_nxt;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_overrun, r_frame_err, r_irq_en, r_irq;
  logic        w_rx_fall;
  logic        w_rx_shift_en;
  logic        w_rx_done;
  logic        w_rx_ferr;

  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign irq       = r_irq;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX next-state: verify start at half a bit, then sample every 16 ticks.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_en  = 1'b0;
    w_rx_done      = 1'b0;
    w_rx_ferr      = 1'b0;
    if (w_tick && (r_rx_state != ST_IDLE)) begin
      w_rx_cnt_nxt = r_rx_cnt + 4'd1;
    end
    unique case (r_rx_state)
      ST_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_nxt = ST_START;
          w_rx_cnt_nxt   = 4'd0;
          w_rx_idx_nxt   = 3'd0;
        end
      end
      ST_START: begin
        if (w_tick && (r_rx_cnt == 4'd7)) begin
          w_rx_cnt_nxt   = 4'd0;
          w_rx_state_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick && (r_rx_cnt == 4'd15)) begin
          w_rx_shift_en = 1'b1;
          if (r_rx_idx == 3'd7) begin
            w_rx_state_nxt = ST_STOP;
          end else begin
            w_rx_idx_nxt = r_rx_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick && (r_rx_cnt == 4'd15)) begin
          w_rx_state_nxt = ST_IDLE;
          w_rx_done      = r_rx_s2;
          w_rx_ferr      = ~r_rx_s2;
        end
      end
      default: w_rx_state_nxt = ST_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= 4'd0;
      r_rx_idx   <= 3'd0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
    end
  end

  // Status flags and interrupt; hardware sets take priority over clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_rx_done) begin
        r_rx_valid <= 1'b1;
      end else if (w_rd_rxd) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid) begin
        r_overrun <= 1'b1;
      end else if (w_wr_con && wdata[CON_OVERRUN]) begin
        r_overrun <= 1'b0;
      end
      if (w_rx_ferr) begin
        r_frame_err <= 1'b1;
      end else if (w_wr_con && wdata[CON_FRAME_ERR]) begin
        r_frame_err <= 1'b0;
      end
      if (w_wr_con) begin
        r_irq_en <= wdata[CON_IRQ_EN];
      end
      r_irq <= r_irq_en & r_rx_valid;
    end
  end

  // Data-path registers carry no reset; their contents are qualified by flags.
  always_ff @(posedge clk) begin
    if (w_tx_accept) begin
      r_tx_data <= wdata[7:0];
    end
    if (w_rx_shift_en) begin
      r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end
    if (w_rx_done) begin
      r_rx_data <= r_rx_shift;
    end
  end

  // Combinational load data; zero unless a mapped readable register is hit.
  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      if (w_hit_rxd) begin
        rdata = {24'd0, r_rx_data};
      end else if (w_hit_con) begin
        rdata[CON_TX_BUSY]   = w_tx_busy;
        rdata[CON_RX_VALID]  = r_rx_valid;
        rdata[CON_OVERRUN]   = r_overrun;
        rdata[CON_FRAME_ERR] = r_frame_err;
        rdata[CON_IRQ_EN]    = r_irq_en;
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Randomized self-checking bench for uart_mmio_port with a behavioural model
// of the register file and a serial-line decoder for the transmitter.
module tb_uart_mmio_port;

  localparam int          BAUD    = 9600;
  localparam int          CLK_HZ  = 64 * BAUD;
  localparam int          BIT_CLK = 64;
  localparam logic [31:0] BASE    = 32'h4000_0018;
  localparam logic [31:0] A_TXD   = BASE;
  localparam logic [31:0] A_RXD   = BASE + 32'd4;
  localparam logic [31:0] A_CON   = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic        uart_rx, uart_tx, irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the software-visible receive state.
  logic       exp_valid, exp_ovr, exp_ferr, exp_irq_en;
  logic [7:0] exp_data;
  logic [7:0] exp_tx_q[$];

  // Bytes decoded from uart_tx, their stop-bit values and start-edge times.
  logic [7:0] mon_q[$];
  logic       mon_stop_q[$];
  time        mon_t_q[$];

  always #5 clk = ~clk;

  uart_mmio_port #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_con();
    return {27'd0, exp_irq_en, exp_ferr, exp_ovr, exp_valid, 1'b0};
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    wr_en = 1'b1; addr = a; wdata = d;
    #1;
    while (!ready && waits < 20000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!ready) check_eq("wr_ready_timeout", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    #1;
    d = rdata;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic con_write(input logic [31:0] d);
    int w;
    bus_write(A_CON, d, w);
    exp_irq_en = d[4];
    if (d[3]) exp_ferr = 1'b0;
    if (d[2]) exp_ovr  = 1'b0;
  endtask

  task automatic con_check(input string tag);
    logic [31:0] d;
    bus_read(A_CON, d);
    check_eq(tag, d, exp_con());
  endtask

  task automatic rxd_check(input string tag);
    logic [31:0] d;
    bus_read(A_RXD, d);
    check_eq(tag, d, {24'd0, exp_data});
    exp_valid = 1'b0;
  endtask

  task automatic irq_check(input string tag);
    repeat (2) @(negedge clk);
    check_eq(tag, 32'(irq), 32'(exp_irq_en & exp_valid));
  endtask

  // Drive one 8N1 frame on uart_rx and apply it to the model.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BIT_CLK) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT_CLK / 4) @(negedge clk);
    if (stop) begin
      if (exp_valid) exp_ovr = 1'b1;
      exp_data  = b;
      exp_valid = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic wait_mon(input int n, input int budget);
    for (int k = 0; k < budget && mon_q.size() < n; k++) @(negedge clk);
    check_eq("tx_frame_count", 32'(mon_q.size()), 32'(n));
  endtask

  task automatic mon_clear();
    mon_q.delete();
    mon_stop_q.delete();
    mon_t_q.delete();
  endtask

  // Decode frames seen on uart_tx by sampling mid-bit.
  always begin : tx_monitor
    logic [7:0] b;
    logic       s;
    time        t0;
    @(negedge uart_tx);
    t0 = $time;
    repeat (BIT_CLK / 2) @(negedge clk);
    if (uart_tx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CLK) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (BIT_CLK) @(negedge clk);
      s = uart_tx;
      mon_q.push_back(b);
      mon_stop_q.push_back(s);
      mon_t_q.push_back(t0);
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] d;
    logic [7:0]  b;
    int          w;
    int          lows;

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_irq_en = 1'b0; exp_data = 8'd0;

    repeat (5) @(negedge clk);
    check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("idle_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("idle_ready", 32'(ready), 32'd1);
    con_check("idle_con");

    // Single TX frame.
    exp_tx_q.push_back(8'hA5);
    bus_write(A_TXD, 32'h0000_00A5, w);
    check_eq("tx_first_write_waits", 32'(w), 32'd0);
    repeat (100) @(negedge clk);
    bus_read(A_CON, d);
    check_eq("tx_busy_during", 32'(d[0]), 32'd1);
    wait_mon(1, 2000);
    if (mon_q.size() >= 1) begin
      check_eq("tx_byte_a5", 32'(mon_q[0]), 32'(exp_tx_q[0]));
      check_eq("tx_stop_a5", 32'(mon_stop_q[0]), 32'd1);
    end
    repeat (40) @(negedge clk);
    bus_read(A_CON, d);
    check_eq("tx_busy_after", d, 32'd0);
    mon_clear(); exp_tx_q.delete();

    // Back-to-back writes: second stalls, frames abut exactly.
    bus_write(A_TXD, 32'h55, w);
    check_eq("b2b_first_waits", 32'(w), 32'd0);
    bus_write(A_TXD, 32'h0F, w);
    check_eq("b2b_stall_window", 32'(w >= 600 && w <= 650), 32'd1);
    wait_mon(2, 2500);
    if (mon_q.size() >= 2) begin
      check_eq("b2b_byte0", 32'(mon_q[0]), 32'h55);
      check_eq("b2b_byte1", 32'(mon_q[1]), 32'h0F);
      check_eq("b2b_stop1", 32'(mon_stop_q[1]), 32'd1);
      check_eq("b2b_start_spacing", 32'(mon_t_q[1] - mon_t_q[0]), 32'(10 * BIT_CLK * 10));
    end
    repeat (80) @(negedge clk);
    mon_clear();

    // Random TX burst compared against the queue of written bytes.
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_tx_q.push_back(b);
      bus_write(A_TXD, {24'd0, b}, w);
    end
    wait_mon(3, 2500);
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      check_eq("tx_rand_byte", 32'(mon_q[i]), 32'(exp_tx_q[i]));
      check_eq("tx_rand_stop", 32'(mon_stop_q[i]), 32'd1);
    end
    repeat (80) @(negedge clk);

    // RX with interrupt enabled.
    con_write(32'h10);
    rx_frame(8'h3C, 1'b1);
    con_check("rx_con_valid");
    check_eq("rx_irq_set", 32'(irq), 32'd1);
    rxd_check("rx_data_3c");
    con_check("rx_con_cleared");
    irq_check("rx_irq_drop");

    // Overrun: second byte overwrites, W1C keeps irq_en.
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    con_check("ovr_con");
    rxd_check("ovr_data_22");
    con_write(32'h14);
    con_check("ovr_cleared");

    // Frame error leaves the held byte untouched.
    rx_frame(8'h77, 1'b1);
    rx_frame(8'h99, 1'b0);
    con_check("ferr_con");
    rxd_check("ferr_keeps_77");
    con_write(32'h18);
    con_check("ferr_cleared");

    // Short low glitch is rejected as a false start.
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    con_check("glitch_con");

    // Unmapped and write-only/read-only corners.
    bus_read(BASE + 32'd12, d);
    check_eq("unmapped_read", d, 32'd0);
    bus_write(BASE + 32'd12, 32'hFFFF_FFFF, w);
    check_eq("unmapped_write_waits", 32'(w), 32'd0);
    bus_read(A_TXD, d);
    check_eq("txd_read_zero", d, 32'd0);
    bus_write(A_RXD, 32'h0000_00FF, w);
    con_check("rxd_write_ignored");

    // Randomized RX traffic against the model.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_frame(b, ($urandom_range(0, 3) != 0));
      con_check("rand_con_after_frame");
      irq_check("rand_irq");
      if ($urandom_range(0, 1) == 1) rxd_check("rand_rxd");
      if ($urandom_range(0, 1) == 1) con_write($urandom & 32'h1C);
      con_check("rand_con");
    end

    // Reset in the middle of a TX frame.
    con_write(32'h10);
    bus_write(A_TXD, 32'h00, w);
    repeat (200) @(negedge clk);
    check_eq("pre_reset_tx_low", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("reset_tx_high", 32'(uart_tx), 32'd1);
    check_eq("reset_irq", 32'(irq), 32'd0);
    rd_en = 1'b1; addr = A_CON;
    #1;
    check_eq("reset_con", rdata, 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0; exp_irq_en = 1'b0;
    lows = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) lows++;
    end
    check_eq("post_reset_tx_idle", 32'(lows), 32'd0);
    con_check("post_reset_con");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
